// File: rtl/seq_shift_unit.sv
// seq_shift_unit -- multi-cycle shift unit for the ALU.
//
// Purpose:
//   Accepts a WIDTH-bit operand and a shift amount on a start/ready handshake.
//   It then shifts the result register by one bit per clock until the amount
//   reaches zero, and pulses valid for one cycle. The result holds on Y until
//   the next accepted start.
//
// Ports:
//   clk    in   1      clock; all state changes on the rising edge
//   rst    in   1      synchronous, active-high reset (takes priority over start)
//   start  in   1      request; taken only while ready=1
//   A      in   WIDTH  operand, sampled on the accepting edge
//   shamt  in   SHW    shift amount, sampled on the accepting edge
//   dir    in   1      0 = left (toward MSB), 1 = right (toward LSB)
//   arith  in   1      right shifts: 1 = replicate MSB, 0 = zero fill
//   rot    in   1      (SEQ_SHIFT_ROTATE_EN only) 1 = rotate, overrides arith
//   ready  out  1      high in IDLE only
//   valid  out  1      one-cycle pulse, result on Y
//   Y      out  WIDTH  result register
//
// Build option:
//   SEQ_SHIFT_ROTATE_EN -- adds the rot input and rotate capability.

module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             arith,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] Y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
`ifdef SEQ_SHIFT_ROTATE_EN
  logic             rot_q, rot_d;
`endif

  // One-bit step of the latched operation. Each step derives the bit that
  // enters at the vacated end.
  logic             fill_left, fill_right;
  logic [WIDTH-1:0] y_step;

  always_comb begin
`ifdef SEQ_SHIFT_ROTATE_EN
    fill_left  = rot_q ? y_q[WIDTH-1] : 1'b0;
    fill_right = rot_q ? y_q[0] : (arith_q & y_q[WIDTH-1]);
`else
    fill_left  = 1'b0;
    fill_right = arith_q & y_q[WIDTH-1];
`endif
    y_step = dir_q ? {fill_right, y_q[WIDTH-1:1]}
                   : {y_q[WIDTH-2:0], fill_left};
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and infers a latch.
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
`ifdef SEQ_SHIFT_ROTATE_EN
    rot_d   = rot_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          y_d     = A;
          cnt_d   = shamt;
          dir_d   = dir;
          arith_d = arith;
`ifdef SEQ_SHIFT_ROTATE_EN
          rot_d   = rot;
`endif
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        y_d   = y_step;
        // Leaving on cnt==1 means the counter stops at 0 and never wraps.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);
  assign Y     = y_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed testbench for seq_shift_unit. Expected values are hand-computed.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_seq_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        dir;
  logic        arith;
`ifdef SEQ_SHIFT_ROTATE_EN
  logic        rot;
`endif
  logic        ready;
  logic        valid;
  logic [31:0] Y;

  int n_cmp = 0;
  int n_err = 0;

  seq_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .dir   (dir),
    .arith (arith),
`ifdef SEQ_SHIFT_ROTATE_EN
    .rot   (rot),
`endif
    .ready (ready),
    .valid (valid),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one operation and check its latency (valid cycles after the accepting
  // edge), its result, and the return to IDLE. After acceptance, the operand
  // inputs are scrambled to confirm that the DUT ignores them.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                       input logic d, input logic ar, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    A = a; shamt = sh; dir = d; arith = ar; start = 1'b1;
    check({tag, "_ready"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; A = ~a; shamt = ~sh; dir = ~d; arith = ~ar;
    @(negedge clk);
    cyc = 0;
    while (!valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(sh));
    check({tag, "_Y"}, Y, exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    check({tag, "_ready_back"}, 32'(ready), 32'd1);
    check({tag, "_Y_hold"}, Y, exp);
  endtask

  initial begin
    int pulses;

    // 1. Reset with start held high: nothing is accepted.
    rst = 1'b1; start = 1'b1; A = 32'hA5A5_A5A5; shamt = 5'd3; dir = 1'b0; arith = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
    rot = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_Y", Y, 32'h0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_Y", Y, 32'h0);

    // 2. Left shift.
    do_op("lsl4", 32'h0000_0001, 5'd4, 1'b0, 1'b0, 32'h0000_0010);
    do_op("lsl1_arith_ignored", 32'h8000_0001, 5'd1, 1'b0, 1'b1, 32'h0000_0002);

    // 3. Right shifts at the maximum amount.
    do_op("lsr31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
    do_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
    do_op("asr3_pos", 32'h4000_0000, 5'd3, 1'b1, 1'b1, 32'h0800_0000);

    // 4. Zero amount; a second start while busy is ignored.
    @(negedge clk);
    A = 32'hDEAD_BEEF; shamt = 5'd0; dir = 1'b0; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h1234_5678; shamt = 5'd5;  // start stays high while busy
    @(negedge clk);
    check("zero_valid", 32'(valid), 32'd1);
    check("zero_ready_busy", 32'(ready), 32'd0);
    check("zero_Y", Y, 32'hDEAD_BEEF);
    pulses = 1;
    @(negedge clk);
    start = 1'b0;
    check("zero_valid_drop", 32'(valid), 32'd0);
    check("zero_ready_back", 32'(ready), 32'd1);
    repeat (10) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("zero_pulse_count", 32'(pulses), 32'd1);
    check("zero_Y_hold", Y, 32'hDEAD_BEEF);

    // 5. Reset after five SHIFT cycles aborts the operation.
    @(negedge clk);
    A = 32'hFFFF_FFFF; shamt = 5'd20; dir = 1'b0; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = 32'h0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_Y_5", Y, 32'hFFFF_FFE0);
    check("mid_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_Y", Y, 32'h0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    do_op("after_abort", 32'h0000_00F0, 5'd4, 1'b1, 1'b0, 32'h0000_000F);

`ifdef SEQ_SHIFT_ROTATE_EN
    // 6. Rotates; rot overrides arith.
    rot = 1'b1;
    do_op("rol1", 32'h8000_0001, 5'd1, 1'b0, 1'b0, 32'h0000_0003);
    do_op("ror1", 32'h8000_0001, 5'd1, 1'b1, 1'b1, 32'hC000_0000);
    rot = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
